// File: rtl/nand4_arb_defs.sv
// Shared constants and types for the 4-requester NAND4 arbiter.
package nand4_arb_defs;

    // Requester count, operand width per requester and requester index width.
    localparam int N_REQ  = 4;
    localparam int OPND_W = 4;
    localparam int IDX_W  = 2;

    // Arbiter FSM; encoding 2'd3 is unused and recovers to IDLE.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EVAL = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Round-robin pointer advance: the requester after the winner, modulo N_REQ.
    function automatic logic [IDX_W-1:0] next_ptr(input logic [IDX_W-1:0] idx);
        return idx + IDX_W'(1);
    endfunction

endpackage

// File: rtl/nand4_arbiter_rr_pick4.sv
// Combinational round-robin picker: searches upward from ptr (mod 4) for the
// first set request bit and reports it one-hot and as an index.
module rr_pick4
    import nand4_arb_defs::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N_REQ-1:0] gnt_oh,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             any_req
);

    logic [IDX_W-1:0] cand;

    // Scan offsets from farthest to nearest so the nearest match to ptr wins.
    always_comb begin
        gnt_oh  = '0;
        gnt_idx = '0;
        cand    = '0;
        any_req = |req;
        for (int off = N_REQ - 1; off >= 0; off--) begin
            cand = ptr + IDX_W'(off);
            if (req[cand]) begin
                gnt_idx = cand;
            end
        end
        if (any_req) begin
            gnt_oh = N_REQ'(1) << gnt_idx;
        end
    end

endmodule

// File: rtl/nand4_arbiter.sv
// Shares a single 4-input NAND among four requesters. Each transaction takes
// three cycles: IDLE (arbitrate and latch operand), EVAL (compute and report),
// DONE (release grant and advance the round-robin pointer).
module nand4_arbiter
    import nand4_arb_defs::*;
#(
    parameter int CNT_W = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [N_REQ-1:0]          req,
    input  logic [N_REQ*OPND_W-1:0]   opnd,
    output logic [N_REQ-1:0]          gnt,
    output logic                      busy,
    output logic                      result,
    output logic                      result_valid,
    output logic [IDX_W-1:0]          result_id,
    output logic [CNT_W-1:0]          op_count
);

    state_e            state_q;
    state_e            state_d;
    logic [IDX_W-1:0]  ptr_q;
    logic [IDX_W-1:0]  win_q;
    logic [OPND_W-1:0] opnd_lat;

    logic [N_REQ-1:0]  pick_oh;
    logic [IDX_W-1:0]  pick_idx;
    logic              pick_any;

    rr_pick4 u_pick (
        .req     (req),
        .ptr     (ptr_q),
        .gnt_oh  (pick_oh),
        .gnt_idx (pick_idx),
        .any_req (pick_any)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; requests are only looked at while IDLE.
    always_comb begin
        state_d = ST_IDLE;
        case (state_q)
            ST_IDLE: state_d = pick_any ? ST_EVAL : ST_IDLE;
            ST_EVAL: state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Winner and operand capture on IDLE->EVAL; later opnd changes are ignored.
    always_ff @(posedge clk) begin
        if (state_q == ST_IDLE && pick_any) begin
            win_q    <= pick_idx;
            opnd_lat <= opnd[pick_idx*OPND_W +: OPND_W];
        end
    end

    // Grant, pointer, result and counter registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            gnt          <= '0;
            ptr_q        <= '0;
            result       <= 1'b0;
            result_valid <= 1'b0;
            result_id    <= '0;
            op_count     <= '0;
        end else begin
            result_valid <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    gnt <= pick_any ? pick_oh : '0;
                end
                ST_EVAL: begin
                    result       <= ~(&opnd_lat);
                    result_valid <= 1'b1;
                    result_id    <= win_q;
                    op_count     <= op_count + CNT_W'(1);
                end
                ST_DONE: begin
                    gnt   <= '0;
                    ptr_q <= next_ptr(win_q);
                end
                default: begin
                    gnt <= '0;
                end
            endcase
        end
    end

    assign busy = (state_q != ST_IDLE);

endmodule

// File: tb/tb_nand4_arbiter.sv
// Directed bench for nand4_arbiter; a second instance with CNT_W=2 shares the
// stimulus to exercise counter wrap.
module tb_nand4_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  req;
    logic [15:0] opnd;

    logic [3:0]  gnt;
    logic        busy;
    logic        result;
    logic        result_valid;
    logic [1:0]  result_id;
    logic [7:0]  op_count;

    logic [3:0]  gnt2;
    logic        busy2;
    logic        result2;
    logic        result_valid2;
    logic [1:0]  result_id2;
    logic [1:0]  op_count2;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    nand4_arbiter #(.CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .opnd(opnd),
        .gnt(gnt), .busy(busy), .result(result), .result_valid(result_valid),
        .result_id(result_id), .op_count(op_count)
    );

    nand4_arbiter #(.CNT_W(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .req(req), .opnd(opnd),
        .gnt(gnt2), .busy(busy2), .result(result2), .result_valid(result_valid2),
        .result_id(result_id2), .op_count(op_count2)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [3:0] exp_res [4] = '{4'd1, 4'd1, 4'd0, 4'd1};

    initial begin
        rst_n = 1'b0;
        req   = 4'b0000;
        opnd  = 16'h0000;
        tick();
        tick();
        chk("rst_gnt", 32'(gnt), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_result", 32'(result), 32'h0);
        chk("rst_rv", 32'(result_valid), 32'h0);
        chk("rst_id", 32'(result_id), 32'h0);
        chk("rst_cnt", 32'(op_count), 32'h0);

        rst_n = 1'b1;
        tick();
        chk("idle_gnt", 32'(gnt), 32'h0);
        chk("idle_busy", 32'(busy), 32'h0);

        // Single requester 1 with operand F.
        req  = 4'b0010;
        opnd = 16'h00F0;
        tick();
        chk("t1_gnt", 32'(gnt), 32'h2);
        chk("t1_busy", 32'(busy), 32'h1);
        chk("t1_rv_early", 32'(result_valid), 32'h0);
        req = 4'b0000;
        tick();
        chk("t1_rv", 32'(result_valid), 32'h1);
        chk("t1_result", 32'(result), 32'h0);
        chk("t1_id", 32'(result_id), 32'h1);
        chk("t1_gnt_hold", 32'(gnt), 32'h2);
        chk("t1_cnt", 32'(op_count), 32'h1);
        tick();
        chk("t1_gnt_low", 32'(gnt), 32'h0);
        chk("t1_rv_low", 32'(result_valid), 32'h0);
        tick();
        chk("t1_busy_low", 32'(busy), 32'h0);

        // Requester 3 with operand 7, changed to F after the grant.
        req  = 4'b1000;
        opnd = 16'h7000;
        tick();
        chk("t2_gnt", 32'(gnt), 32'h8);
        opnd = 16'hF000;
        tick();
        chk("t2_rv", 32'(result_valid), 32'h1);
        chk("t2_result", 32'(result), 32'h1);
        chk("t2_id", 32'(result_id), 32'h3);
        req = 4'b0000;
        tick();
        tick();
        chk("t2_res_hold", 32'(result), 32'h1);
        chk("t2_id_hold", 32'(result_id), 32'h3);
        chk("t2_cnt", 32'(op_count), 32'h2);

        // Requester 2 drops req during EVAL; requester 3 arrives then.
        req  = 4'b0100;
        opnd = 16'h0F00;
        tick();
        chk("t3_gnt", 32'(gnt), 32'h4);
        req = 4'b1000;
        tick();
        chk("t3_rv", 32'(result_valid), 32'h1);
        chk("t3_id", 32'(result_id), 32'h2);
        chk("t3_result", 32'(result), 32'h0);
        tick();
        chk("t3_done_gnt", 32'(gnt), 32'h0);
        tick();
        chk("t3_next_gnt", 32'(gnt), 32'h8);
        req = 4'b0000;
        tick();
        chk("t3_next_id", 32'(result_id), 32'h3);
        tick();
        chk("t3_cnt", 32'(op_count), 32'h4);

        // Reset during EVAL aborts the transaction.
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        req   = 4'b0100;
        tick();
        chk("t4_gnt", 32'(gnt), 32'h4);
        rst_n = 1'b0;
        tick();
        chk("t4_rv", 32'(result_valid), 32'h0);
        chk("t4_gnt0", 32'(gnt), 32'h0);
        chk("t4_cnt", 32'(op_count), 32'h0);
        chk("t4_busy", 32'(busy), 32'h0);
        rst_n = 1'b1;
        req   = 4'b1001;
        tick();
        chk("t4_ptr0_gnt", 32'(gnt), 32'h1);
        req = 4'b0000;
        tick();
        chk("t4_ptr0_id", 32'(result_id), 32'h0);
        tick();

        // All requesters held for 8 transactions from reset.
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        req   = 4'b1111;
        opnd  = 16'h7F3E;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk($sformatf("rr_gnt%0d", i), 32'(gnt), 32'(4'b0001 << (i % 4)));
            tick();
            chk($sformatf("rr_rv%0d", i), 32'(result_valid), 32'h1);
            chk($sformatf("rr_id%0d", i), 32'(result_id), 32'(i % 4));
            chk($sformatf("rr_res%0d", i), 32'(result), 32'(exp_res[i % 4]));
            if (i < 5) begin
                chk($sformatf("wrap_cnt%0d", i), 32'(op_count2), 32'((i + 1) % 4));
            end
            tick();
        end
        req = 4'b0000;
        chk("rr_cnt8", 32'(op_count), 32'h8);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
